// File: rtl/oven_cook_controller_pkg.sv
// Shared oven definitions: FSM state encodings, state/digit widths and the
// BCD MM:SS time record used by the controller and its timer.
package oven_cook_controller_pkg;

    localparam int STATE_W = 3;
    localparam int DIGIT_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_COOKING = 3'd1,
        ST_PAUSED  = 3'd2,
        ST_DONE    = 3'd3
    } oven_state_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] min_tens;
        logic [DIGIT_W-1:0] min_ones;
        logic [DIGIT_W-1:0] sec_tens;
        logic [DIGIT_W-1:0] sec_ones;
    } mmss_t;

    function automatic logic mmss_is_zero(input mmss_t v);
        return (v == '0);
    endfunction

endpackage

// File: rtl/oven_cook_controller_bcd_mmss_timer.sv
// BCD MM:SS register with clear, saturating add and borrow-decrement.
// The add result feeds the decrement so a coincident add+tick adds first.
module bcd_mmss_timer
    import oven_cook_controller_pkg::*;
#(
    parameter int MAX_MIN  = 99,
    parameter int SEC_STEP = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               add_min_i,
    input  logic               add_sec_i,
    input  logic               dec_i,
    output logic [DIGIT_W-1:0] min_tens_o,
    output logic [DIGIT_W-1:0] min_ones_o,
    output logic [DIGIT_W-1:0] sec_tens_o,
    output logic [DIGIT_W-1:0] sec_ones_o,
    output logic               zero_o,
    output logic               next_zero_o
);

    localparam logic [DIGIT_W-1:0] MAX_T  = DIGIT_W'(MAX_MIN / 10);
    localparam logic [DIGIT_W-1:0] MAX_O  = DIGIT_W'(MAX_MIN % 10);
    localparam logic [DIGIT_W-1:0] STEP_T = DIGIT_W'(SEC_STEP / 10);

    mmss_t time_q, time_d, add_t;

    function automatic logic at_max_min(input mmss_t v);
        return (v.min_tens == MAX_T) && (v.min_ones == MAX_O);
    endfunction

    function automatic mmss_t sat_time();
        mmss_t r;
        r.min_tens = MAX_T;
        r.min_ones = MAX_O;
        r.sec_tens = 4'd5;
        r.sec_ones = 4'd9;
        return r;
    endfunction

    // At the minute limit a further minute pins the whole time at MAX:59.
    function automatic mmss_t inc_min(input mmss_t v);
        mmss_t r;
        r = v;
        if (at_max_min(v)) begin
            r = sat_time();
        end else if (v.min_ones == 4'd9) begin
            r.min_ones = 4'd0;
            r.min_tens = v.min_tens + 4'd1;
        end else begin
            r.min_ones = v.min_ones + 4'd1;
        end
        return r;
    endfunction

    // SEC_STEP is a multiple of ten, so only the tens digit moves.
    function automatic mmss_t inc_sec(input mmss_t v);
        mmss_t              r;
        logic [DIGIT_W-1:0] tens_sum;
        r        = v;
        tens_sum = v.sec_tens + STEP_T;
        if (tens_sum >= 4'd6) begin
            if (at_max_min(v)) begin
                r = sat_time();
            end else begin
                r          = inc_min(v);
                r.sec_tens = tens_sum - 4'd6;
            end
        end else begin
            r.sec_tens = tens_sum;
        end
        return r;
    endfunction

    function automatic mmss_t dec_one(input mmss_t v);
        mmss_t r;
        r = v;
        if (v.sec_ones != 4'd0) begin
            r.sec_ones = v.sec_ones - 4'd1;
        end else begin
            r.sec_ones = 4'd9;
            if (v.sec_tens != 4'd0) begin
                r.sec_tens = v.sec_tens - 4'd1;
            end else begin
                r.sec_tens = 4'd5;
                if (v.min_ones != 4'd0) begin
                    r.min_ones = v.min_ones - 4'd1;
                end else begin
                    r.min_ones = 4'd9;
                    r.min_tens = v.min_tens - 4'd1;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        add_t = time_q;
        if (add_min_i) add_t = inc_min(add_t);
        if (add_sec_i) add_t = inc_sec(add_t);
        time_d = add_t;
        if (dec_i && !mmss_is_zero(add_t)) time_d = dec_one(add_t);
        if (clear_i) time_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) time_q <= '0;
        else     time_q <= time_d;
    end

    assign min_tens_o  = time_q.min_tens;
    assign min_ones_o  = time_q.min_ones;
    assign sec_tens_o  = time_q.sec_tens;
    assign sec_ones_o  = time_q.sec_ones;
    assign zero_o      = mmss_is_zero(time_q);
    assign next_zero_o = mmss_is_zero(time_d);

endmodule

// File: rtl/oven_cook_controller.sv
// Cook-cycle sequencer: FSM, door interlock, beep counter and registered
// heater/light/beep/done outputs around the BCD countdown timer.
module oven_cook_controller
    import oven_cook_controller_pkg::*;
#(
    parameter int MAX_MIN   = 99,
    parameter int BEEP_SECS = 3,
    parameter int SEC_STEP  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic               start,
    input  logic               stop,
    input  logic               add_min,
    input  logic               add_sec,
    input  logic               door_open,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               heater_on,
    output logic               light_on,
    output logic               beep,
    output logic               done,
    output logic [STATE_W-1:0] state
);

    localparam logic [3:0] BEEP_LD = 4'(BEEP_SECS);

    oven_state_t state_q, state_d;
    logic [3:0]  beep_cnt_q, beep_cnt_d;
    logic        heater_q, light_q, beep_q, done_q;
    logic        clr, do_add_min, do_add_sec, do_dec;
    logic        time_zero, time_next_zero;

    bcd_mmss_timer #(
        .MAX_MIN  (MAX_MIN),
        .SEC_STEP (SEC_STEP)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clr),
        .add_min_i   (do_add_min),
        .add_sec_i   (do_add_sec),
        .dec_i       (do_dec),
        .min_tens_o  (min_tens),
        .min_ones_o  (min_ones),
        .sec_tens_o  (sec_tens),
        .sec_ones_o  (sec_ones),
        .zero_o      (time_zero),
        .next_zero_o (time_next_zero)
    );

    always_comb begin
        state_d    = state_q;
        beep_cnt_d = beep_cnt_q;
        clr        = 1'b0;
        do_add_min = 1'b0;
        do_add_sec = 1'b0;
        do_dec     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (stop) begin
                    clr = 1'b1;
                end else if (start && !door_open && !time_zero) begin
                    state_d = ST_COOKING;
                end else if (!start) begin
                    do_add_min = add_min;
                    do_add_sec = add_sec;
                end
            end
            ST_COOKING: begin
                if (door_open || stop) begin
                    state_d = ST_PAUSED;
                end else begin
                    do_add_min = add_min;
                    do_add_sec = add_sec;
                    do_dec     = tick_1hz;
                    if (tick_1hz && time_next_zero) begin
                        state_d    = ST_DONE;
                        beep_cnt_d = BEEP_LD;
                    end
                end
            end
            ST_PAUSED: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    clr     = 1'b1;
                end else if (start && !door_open) begin
                    state_d = ST_COOKING;
                end else if (!start) begin
                    do_add_min = add_min;
                    do_add_sec = add_sec;
                end
            end
            ST_DONE: begin
                if (door_open || stop) begin
                    state_d = ST_IDLE;
                end else if (tick_1hz) begin
                    // The tick that empties the counter also silences the beeper.
                    if (beep_cnt_q <= 4'd1) begin
                        state_d    = ST_IDLE;
                        beep_cnt_d = 4'd0;
                    end else begin
                        beep_cnt_d = beep_cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            beep_cnt_q <= 4'd0;
            heater_q   <= 1'b0;
            light_q    <= 1'b0;
            beep_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beep_cnt_q <= beep_cnt_d;
            heater_q   <= (state_d == ST_COOKING);
            light_q    <= (state_d == ST_COOKING) || ((state_d == ST_PAUSED) && door_open);
            beep_q     <= (state_d == ST_DONE);
            done_q     <= (state_d == ST_DONE) && (state_q != ST_DONE);
        end
    end

    assign heater_on = heater_q;
    assign light_on  = light_q;
    assign beep      = beep_q;
    assign done      = done_q;
    assign state     = state_q;

endmodule

// File: tb/tb_oven_cook_controller.sv
// Scoreboard bench: a seconds-based reference model predicts every cycle's
// outputs; predictions are queued at drive time and popped after the edge.
module tb_oven_cook_controller;
    localparam int MAX_MIN   = 99;
    localparam int BEEP_SECS = 3;
    localparam int SEC_STEP  = 10;
    localparam int T_MAX     = MAX_MIN * 60 + 59;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0, start = 1'b0, stop = 1'b0;
    logic       add_min = 1'b0, add_sec = 1'b0, door_open = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       heater_on, light_on, beep, done;
    logic [2:0] state;

    oven_cook_controller #(
        .MAX_MIN   (MAX_MIN),
        .BEEP_SECS (BEEP_SECS),
        .SEC_STEP  (SEC_STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .start     (start),
        .stop      (stop),
        .add_min   (add_min),
        .add_sec   (add_sec),
        .door_open (door_open),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .heater_on (heater_on),
        .light_on  (light_on),
        .beep      (beep),
        .done      (done),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tm;
        int st;
        int h;
        int l;
        int b;
        int d;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state: remaining time in plain seconds.
    int   m_t = 0, m_s = 0, m_cnt = 0;
    logic door_lv = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int to_bcd(input int t);
        int m, s;
        m = t / 60;
        s = t % 60;
        return ((m / 10) << 12) | ((m % 10) << 8) | ((s / 10) << 4) | (s % 10);
    endfunction

    function automatic int sat(input int t);
        return (t > T_MAX) ? T_MAX : t;
    endfunction

    task automatic model(input logic tk, st, sp, am, as_, dr, rs);
        exp_t e;
        int   prev;
        prev = m_s;
        if (rs) begin
            m_t = 0; m_s = 0; m_cnt = 0;
        end else begin
            case (m_s)
                0: begin
                    if (sp) m_t = 0;
                    else if (st && !dr && m_t != 0) m_s = 1;
                    else if (!st) begin
                        if (am) m_t = sat(m_t + 60);
                        if (as_) m_t = sat(m_t + SEC_STEP);
                    end
                end
                1: begin
                    if (dr || sp) m_s = 2;
                    else begin
                        if (am) m_t = sat(m_t + 60);
                        if (as_) m_t = sat(m_t + SEC_STEP);
                        if (tk && m_t > 0) begin
                            m_t--;
                            if (m_t == 0) begin m_s = 3; m_cnt = BEEP_SECS; end
                        end
                    end
                end
                2: begin
                    if (sp) begin m_s = 0; m_t = 0; end
                    else if (st && !dr) m_s = 1;
                    else if (!st) begin
                        if (am) m_t = sat(m_t + 60);
                        if (as_) m_t = sat(m_t + SEC_STEP);
                    end
                end
                default: begin
                    if (dr || sp) m_s = 0;
                    else if (tk) begin
                        m_cnt--;
                        if (m_cnt == 0) m_s = 0;
                    end
                end
            endcase
        end
        e.tm = to_bcd(m_t);
        e.st = m_s;
        e.h  = (!rs && m_s == 1) ? 1 : 0;
        e.l  = (!rs && (m_s == 1 || (m_s == 2 && dr))) ? 1 : 0;
        e.b  = (!rs && m_s == 3) ? 1 : 0;
        e.d  = (!rs && m_s == 3 && prev != 3) ? 1 : 0;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic tk, st, sp, am, as_, rs);
        exp_t e;
        tick_1hz  = tk;
        start     = st;
        stop      = sp;
        add_min   = am;
        add_sec   = as_;
        rst       = rs;
        door_open = door_lv;
        model(tk, st, sp, am, as_, door_lv, rs);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk("time",   {16'd0, min_tens, min_ones, sec_tens, sec_ones}, e.tm);
            chk("state",  int'(state), e.st);
            chk("heater", int'(heater_on), e.h);
            chk("light",  int'(light_on), e.l);
            chk("beep",   int'(beep), e.b);
            chk("done",   int'(done), e.d);
        end
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1, 0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0);
        end
    endtask
    task automatic press_start(); step(0, 1, 0, 0, 0, 0); endtask
    task automatic press_stop();  step(0, 0, 1, 0, 0, 0); endtask
    task automatic press_min(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0);
    endtask
    task automatic press_sec(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        int ev;
        logic tk;
        // Reset state
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        nop(1);

        // Full cook from 02:00 through DONE and the beeper timeout
        press_min(2);
        press_start();
        ticks(120);
        ticks(BEEP_SECS);
        nop(2);

        // Door interlock while cooking at 01:00
        press_min(1);
        press_start();
        door_lv = 1'b1;
        nop(1);
        ticks(5);
        press_start();
        door_lv = 1'b0;
        nop(1);
        press_start();
        ticks(2);
        press_stop();
        press_stop();

        // 00:55 + add_sec carries into minutes
        press_min(1);
        press_start();
        ticks(5);
        press_stop();
        press_sec(1);
        press_stop();

        // Saturation at 99:59
        press_min(1);
        press_start();
        ticks(5);
        press_stop();
        press_min(99);
        press_sec(2);
        press_min(1);
        press_stop();

        // Coincident add_min and tick at 02:00, then a lone tick at 01:00
        press_min(2);
        press_start();
        step(1, 0, 0, 1, 0, 0);
        press_stop();
        press_stop();
        press_min(1);
        press_start();
        ticks(1);
        press_stop();
        press_stop();

        // Ignored starts: zero time, door open
        press_start();
        press_sec(3);
        door_lv = 1'b1;
        press_start();
        door_lv = 1'b0;
        press_stop();

        // Reset mid-cook at 00:45
        press_min(1);
        press_start();
        ticks(15);
        step(0, 0, 0, 0, 0, 1);
        nop(1);

        // stop during DONE beep
        press_sec(1);
        press_start();
        ticks(10);
        nop(1);
        press_stop();
        nop(1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            tk = ($urandom_range(0, 2) == 0);
            ev = $urandom_range(0, 19);
            if (ev == 4) door_lv = ~door_lv;
            step(tk, ev == 0 || ev == 5 || ev == 6, ev == 1, ev == 2, ev == 3, ev == 7 && i % 50 == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
